// File: rtl/key_conditioner.sv
// Three-button conditioner with per-channel two-flop synchronizer, debounce FSM,
// registered press pulses, and the action button's debounced level.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_start,
    input  logic btn_restart,
    input  logic btn_action,
    output logic start_game,
    output logic restart,
    output logic action_pulse,
    output logic action_held
);

    localparam int unsigned NumCh  = 3;
    localparam logic [15:0] CntMax = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StReleased,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_e;

    // Channel order: 0 = start, 1 = restart, 2 = action.
    logic [NumCh-1:0] btn_raw;
    logic [NumCh-1:0] sync1_q;
    logic [NumCh-1:0] sync2_q;
    logic [NumCh-1:0] press;

    assign btn_raw = {btn_action, btn_restart, btn_start};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < NumCh; i++) begin : g_ch
        state_e      state_q;
        state_e      state_d;
        logic [15:0] cnt_q;
        logic [15:0] cnt_d;
        logic        press_d;
        logic        level_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StReleased;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            unique case (state_q)
                StReleased: begin
                    if (sync2_q[i]) begin
                        state_d = StPressWait;
                        cnt_d   = 16'd1;
                    end else begin
                        cnt_d   = '0;
                    end
                end
                StPressWait: begin
                    if (!sync2_q[i]) begin
                        state_d = StReleased;
                        cnt_d   = '0;
                    end else if (cnt_q == CntMax) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 16'd1;
                    end
                end
                StPressed: begin
                    if (!sync2_q[i]) begin
                        state_d = StReleaseWait;
                        cnt_d   = 16'd1;
                    end
                end
                StReleaseWait: begin
                    if (sync2_q[i]) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                    end else if (cnt_q == CntMax) begin
                        state_d = StReleased;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end
            endcase
        end

        // Level is taken from the next state so the held output lines up with the pulse.
        assign level_d  = (state_d == StPressed) || (state_d == StReleaseWait);
        assign press[i] = press_d;
    end

    // Restart wins a same-cycle collision; the start channel still latches PRESSED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_game   <= 1'b0;
            restart      <= 1'b0;
            action_pulse <= 1'b0;
            action_held  <= 1'b0;
        end else begin
            start_game   <= press[0] & ~press[1];
            restart      <= press[1];
            action_pulse <= press[2];
            action_held  <= g_ch[2].level_d;
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner at DEBOUNCE_CYCLES=4: vector table plus
// hand-written reset-mid-debounce and long-hold sequences.
module tb_key_conditioner;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic btn_start = 1'b0;
    logic btn_restart = 1'b0;
    logic btn_action = 1'b0;
    logic start_game;
    logic restart;
    logic action_pulse;
    logic action_held;

    int checks = 0;
    int errors = 0;

    key_conditioner #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_start   (btn_start),
        .btn_restart (btn_restart),
        .btn_action  (btn_action),
        .start_game  (start_game),
        .restart     (restart),
        .action_pulse(action_pulse),
        .action_held (action_held)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        logic  s;
        logic  r;
        logic  a;
        logic  es;
        logic  er;
        logic  ep;
        logic  eh;
    } vec_t;

    vec_t vq[$];

    function automatic void add(string tag, logic s, logic r, logic a,
                                logic es, logic er, logic ep, logic eh);
        vec_t v;
        v.tag = tag;
        v.s   = s;
        v.r   = r;
        v.a   = a;
        v.es  = es;
        v.er  = er;
        v.ep  = ep;
        v.eh  = eh;
        vq.push_back(v);
    endfunction

    task automatic chk(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_all(string name, logic es, logic er, logic ep, logic eh);
        chk({name, " start_game"}, start_game, es);
        chk({name, " restart"}, restart, er);
        chk({name, " action_pulse"}, action_pulse, ep);
        chk({name, " action_held"}, action_held, eh);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(string name, int n);
        btn_start   = 1'b0;
        btn_restart = 1'b0;
        btn_action  = 1'b0;
        for (int k = 0; k < n; k++) begin
            step();
            chk_all($sformatf("%s[%0d]", name, k), 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int stray;

        // Clean press on start, then release.
        for (int k = 0; k < 20; k++) add("press", 1'b1, 1'b0, 1'b0, k == 5, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) add("press_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Action glitch of three captured cycles is rejected.
        for (int k = 0; k < 9; k++) add("glitch", 1'b0, 1'b0, k < 3, 1'b0, 1'b0, 1'b0, 1'b0);
        // Action held, then release bounce: low 2, high 1, low 3, high 1, low.
        for (int k = 0; k < 28; k++)
            add("bounce", 1'b0, 1'b0, (k < 10) || (k == 12) || (k == 16),
                1'b0, 1'b0, k == 5, (k >= 5) && (k <= 21));
        // Start and restart together: restart wins.
        for (int k = 0; k < 18; k++)
            add("simul", k < 10, k < 10, 1'b0, 1'b0, k == 5, 1'b0, 1'b0);

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1 chk_all("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("reset_clk0", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("reset_clk1", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle("post_reset", 3);

        foreach (vq[i]) begin
            btn_start   = vq[i].s;
            btn_restart = vq[i].r;
            btn_action  = vq[i].a;
            step();
            chk_all($sformatf("%s[%0d]", vq[i].tag, i), vq[i].es, vq[i].er, vq[i].ep, vq[i].eh);
        end

        // Reset mid-debounce with restart still held through release.
        idle("pre_rst", 2);
        btn_restart = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_all($sformatf("rst_count[%0d]", k), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b0;
        #1 chk_all("rst_mid_async", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all($sformatf("rst_mid_hold[%0d]", k), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk_all($sformatf("rst_release[%0d]", k), 1'b0, k == 6, 1'b0, 1'b0);
        end
        idle("rst_rel_idle", 8);

        // Long hold: exactly one start pulse, at the debounce latency.
        pulses = 0;
        stray  = 0;
        btn_start = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            step();
            if (start_game === 1'b1) pulses++;
            if (restart !== 1'b0 || action_pulse !== 1'b0 || action_held !== 1'b0) stray++;
            if (k == 5) chk("long_hold first pulse", start_game, 1'b1);
            if (k == 6) chk("long_hold pulse width", start_game, 1'b0);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL long_hold pulse count: got %0d expected 1", pulses);
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL long_hold other outputs: got %0d active cycles expected 0", stray);
        end
        idle("long_hold_rel", 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
